img_stream_source: RTL and testbench

Video stream transmitter that produces the frame-synchronous pixel protocol consumed by the image-processing filters: `vsync`, `href` and 8-bit gray.
- Pulls pixels from an upstream valid/ready source, for example a frame-buffer reader or a test-pattern generator.
- Frames them with programmable porch and blanking intervals.
- Drives the `per_img_*` inputs of any filter chain, in simulation and on hardware.

---
 rtl/img_stream_pkg.sv | 17 +
 rtl/img_timing_cnt.sv | 22 ++
 rtl/img_stream_source.sv | 119 +++++++++++
 tb/tb_img_stream_source.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_stream_pkg.sv
// Shared definitions for the gray-scale stream source: state encoding,
// counter widths and default frame timing.
package img_stream_pkg;
  localparam int HW = 11;
  localparam int DW = 16;

  localparam logic [HW-1:0] DEF_IMG_HDISP = 11'd640;
  localparam logic [HW-1:0] DEF_IMG_VDISP = 11'd480;
  localparam logic [DW-1:0] DEF_H_BLANK   = 16'd160;
  localparam logic [DW-1:0] DEF_V_PRE     = 16'd100;
  localparam logic [DW-1:0] DEF_V_POST    = 16'd100;
  localparam logic [DW-1:0] DEF_V_GAP     = 16'd1000;

  typedef enum logic [2:0] {
    ST_IDLE, ST_VPRE, ST_LINE, ST_HBLK, ST_VPOST, ST_GAP
  } state_t;
endpackage

// File: rtl/img_timing_cnt.sv
// Loadable down-counter; tc is high while the count sits at zero.
module img_timing_cnt
  import img_stream_pkg::*;
#(
  parameter int W = DW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/img_stream_source.sv
// Frames an upstream valid/ready pixel stream into vsync/href/gray video
// with fixed, programmable porch and blanking intervals.
module img_stream_source
  import img_stream_pkg::*;
#(
  parameter logic [HW-1:0] IMG_HDISP = DEF_IMG_HDISP,
  parameter logic [HW-1:0] IMG_VDISP = DEF_IMG_VDISP,
  parameter logic [DW-1:0] H_BLANK   = DEF_H_BLANK,
  parameter logic [DW-1:0] V_PRE     = DEF_V_PRE,
  parameter logic [DW-1:0] V_POST    = DEF_V_POST,
  parameter logic [DW-1:0] V_GAP     = DEF_V_GAP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       pix_ready,
  output logic       img_vsync,
  output logic       img_href,
  output logic [7:0] img_gray,
  output logic       frame_done,
  output logic       underrun,
  output logic       busy
);
  state_t          state, state_nxt;
  logic [HW-1:0]   hcnt, vcnt;
  logic [DW-1:0]   dcnt_ld_val;
  logic            dcnt_ld, dcnt_tc;
  logic            line_end, last_line;
  logic            vsync_d, busy_d, fdone_d, href_d;
  logic [7:0]      gray_d;

  assign line_end  = (hcnt == IMG_HDISP - HW'(1));
  assign last_line = (vcnt == IMG_VDISP - HW'(1));
  assign pix_ready = (state == ST_LINE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)    state_nxt = ST_VPRE;
      ST_VPRE:  if (dcnt_tc)  state_nxt = ST_LINE;
      ST_LINE:  if (line_end) state_nxt = ST_HBLK;
      ST_HBLK:  if (dcnt_tc)  state_nxt = !last_line      ? ST_LINE :
                                          (V_POST == '0)  ? ST_GAP  : ST_VPOST;
      ST_VPOST: if (dcnt_tc)  state_nxt = ST_GAP;
      ST_GAP:   if (dcnt_tc)  state_nxt = cont ? ST_VPRE : ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Every state change reloads the interval counter with the new state's length.
  always_comb begin
    dcnt_ld_val = '0;
    case (state_nxt)
      ST_VPRE:  dcnt_ld_val = V_PRE   - DW'(1);
      ST_HBLK:  dcnt_ld_val = H_BLANK - DW'(1);
      ST_VPOST: dcnt_ld_val = V_POST  - DW'(1);
      ST_GAP:   dcnt_ld_val = V_GAP   - DW'(1);
      default:  dcnt_ld_val = '0;
    endcase
  end
  assign dcnt_ld = (state_nxt != state);

  img_timing_cnt #(.W(DW)) u_dcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dcnt_ld),
    .load_val (dcnt_ld_val),
    .tc       (dcnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (state_nxt == ST_LINE && state != ST_LINE) hcnt <= '0;
      else if (state == ST_LINE)                    hcnt <= hcnt + HW'(1);
      if (state_nxt == ST_VPRE)                     vcnt <= '0;
      else if (state == ST_HBLK && state_nxt == ST_LINE) vcnt <= vcnt + HW'(1);
    end
  end

  // Frame-level outputs follow the upcoming state; pixel outputs lag the
  // accepting LINE cycle by one so href and gray stay aligned.
  always_comb begin
    vsync_d = (state_nxt inside {ST_VPRE, ST_LINE, ST_HBLK, ST_VPOST});
    busy_d  = (state_nxt != ST_IDLE);
    fdone_d = (state_nxt == ST_GAP) && (state != ST_GAP);
    href_d  = (state == ST_LINE);
    gray_d  = (state == ST_LINE && pix_valid) ? pix_data : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_vsync  <= 1'b0;
      img_href   <= 1'b0;
      img_gray   <= 8'd0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      img_vsync  <= vsync_d;
      img_href   <= href_d;
      img_gray   <= gray_d;
      frame_done <= fdone_d;
      busy       <= busy_d;
      if (state == ST_IDLE && start)         underrun <= 1'b0;
      else if (state == ST_LINE && !pix_valid) underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_img_stream_source.sv
// Bench for img_stream_source: frame-offset reference model checked every
// cycle, a vector table for the first frame, and hand-written corner cases.
module tb_img_stream_source;
  localparam int HD = 4, VD = 3, HB = 2, VPR = 3, VPO = 3, VG = 5;
  localparam int LT = HD + HB;
  localparam int VTOT = VPR + VD * LT + VPO;
  localparam int PERIOD = VTOT + VG;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'd0;
  logic       pix_ready, img_vsync, img_href, frame_done, underrun, busy;
  logic [7:0] img_gray;

  img_stream_source #(
    .IMG_HDISP(11'd4), .IMG_VDISP(11'd3), .H_BLANK(16'd2),
    .V_PRE(16'd3), .V_POST(16'd3), .V_GAP(16'd5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .img_vsync(img_vsync), .img_href(img_href), .img_gray(img_gray),
    .frame_done(frame_done), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a frame is a fixed timeline measured from its first
  // vsync cycle m_f; everything else is derived from the offset into it.
  logic       m_act = 1'b0, m_und = 1'b0, m_href = 1'b0;
  logic [7:0] m_gray = 8'd0;
  int         m_f = 0, m_off;
  logic       m_ready;

  always_comb begin
    m_off   = cyc - m_f;
    m_ready = m_act && (m_off >= VPR) && (m_off < VPR + VD * LT) &&
              (((m_off - VPR) % LT) < HD);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_und <= 1'b0; m_href <= 1'b0; m_gray <= 8'd0;
    end else begin
      m_href <= m_ready;
      m_gray <= (m_ready && pix_valid) ? pix_data : 8'd0;
      if (m_ready && !pix_valid) m_und <= 1'b1;
      if (!m_act) begin
        if (start) begin m_act <= 1'b1; m_f <= cyc + 1; m_und <= 1'b0; end
      end else if (cyc == m_f + PERIOD - 1) begin
        if (cont) m_f <= m_f + PERIOD;
        else      m_act <= 1'b0;
      end
    end
  end

  int tests = 0, fails = 0;
  int mode = 0, src_n = 0, slot = 0;
  logic [7:0] gray_q[$];
  logic       und_q[$];
  int         rise_q[$], fd_q[$];
  int         vs_n = 0, fd_n = 0, idle_n = 0, burst_n = 0;
  logic       vs_prev = 1'b0, busy_prev = 1'b0, hr_prev = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_stats();
    gray_q.delete(); und_q.delete(); rise_q.delete(); fd_q.delete();
    vs_n = 0; fd_n = 0; idle_n = 0; burst_n = 0;
  endtask

  // One cycle: compare against the model mid-cycle, gather stats, then drive the source.
  task automatic tick();
    logic [13:0] act, exp;
    @(negedge clk);
    act = {img_vsync, img_href, img_gray, frame_done, busy, underrun, pix_ready};
    exp = {m_act && (m_off < VTOT), m_href, m_gray, m_act && (m_off == VTOT),
           m_act, m_und, m_ready};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL model cyc=%0d got=%b expected=%b (vsync,href,gray8,fd,busy,und,ready)",
               cyc, act, exp);
    end
    if (img_href) begin gray_q.push_back(img_gray); und_q.push_back(underrun); end
    if (img_href && !hr_prev) burst_n++;
    if (img_vsync && !vs_prev) rise_q.push_back(cyc);
    if (frame_done) begin fd_q.push_back(cyc); fd_n++; end
    if (busy_prev && !busy) idle_n++;
    vs_n += int'(img_vsync);
    vs_prev = img_vsync; busy_prev = busy; hr_prev = img_href;
    case (mode)
      0: begin pix_valid = 1'b1; pix_data = 8'(src_n + 1); end
      1: begin pix_valid = !(pix_ready && slot == 1); pix_data = 8'(src_n + 1); end
      2: begin pix_valid = ($urandom_range(3) != 0); pix_data = 8'($urandom); end
      default: begin pix_valid = 1'b1; pix_data = 8'd128; end
    endcase
    if (pix_ready) slot++;
    if (pix_ready && pix_valid) src_n++;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    do begin tick(); n++; end while (busy && n < budget);
    chk("idle_timeout", int'(busy), 0);
  endtask

  int img [VD][HD];

  function automatic int clampv(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  function automatic int gauss(input int y, input int x);
    int w[5] = '{1, 4, 6, 4, 1};
    int s = 0;
    for (int dy = -2; dy <= 2; dy++)
      for (int dx = -2; dx <= 2; dx++)
        s += w[dy + 2] * w[dx + 2] * img[clampv(y + dy, VD - 1)][clampv(x + dx, HD - 1)];
    return (s + 128) / 256;
  endfunction

  typedef struct {
    int c; logic vs; logic hr; logic [7:0] gy; logic fd; logic bz; logic un;
  } vec_t;
  vec_t tv[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tv.push_back('{10, 0, 0, 8'd0,  0, 0, 0});
    tv.push_back('{11, 1, 0, 8'd0,  0, 1, 0});
    tv.push_back('{14, 1, 0, 8'd0,  0, 1, 0});
    tv.push_back('{15, 1, 1, 8'd1,  0, 1, 0});
    tv.push_back('{16, 1, 1, 8'd2,  0, 1, 0});
    tv.push_back('{18, 1, 1, 8'd4,  0, 1, 0});
    tv.push_back('{19, 1, 0, 8'd0,  0, 1, 0});
    tv.push_back('{20, 1, 0, 8'd0,  0, 1, 0});
    tv.push_back('{21, 1, 1, 8'd5,  0, 1, 0});
    tv.push_back('{24, 1, 1, 8'd8,  0, 1, 0});
    tv.push_back('{25, 1, 0, 8'd0,  0, 1, 0});
    tv.push_back('{27, 1, 1, 8'd9,  0, 1, 0});
    tv.push_back('{30, 1, 1, 8'd12, 0, 1, 0});
    tv.push_back('{31, 1, 0, 8'd0,  0, 1, 0});
    tv.push_back('{34, 1, 0, 8'd0,  0, 1, 0});
    tv.push_back('{35, 0, 0, 8'd0,  1, 1, 0});
    tv.push_back('{36, 0, 0, 8'd0,  0, 1, 0});
    tv.push_back('{39, 0, 0, 8'd0,  0, 1, 0});
    tv.push_back('{40, 0, 0, 8'd0,  0, 0, 0});

    // Reset state
    repeat (3) tick();
    chk("reset_outputs", int'({img_vsync, img_href, img_gray, frame_done, busy, underrun, pix_ready}), 0);
    rst_n = 1'b1;

    // 1: single frame, start at cycle 10, counting pixels
    mode = 0; src_n = 0; clr_stats();
    for (int c = 0; c < 46; c++) begin
      tick();
      foreach (tv[i])
        if (tv[i].c == c)
          chk($sformatf("t1_vec_c%0d", c),
              int'({img_vsync, img_href, img_gray, frame_done, busy, underrun}),
              int'({tv[i].vs, tv[i].hr, tv[i].gy, tv[i].fd, tv[i].bz, tv[i].un}));
      start = (c == 10);
    end
    chk("t1_vsync_len", vs_n, VTOT);
    chk("t1_bursts", burst_n, VD);
    chk("t1_pixels", gray_q.size(), VD * HD);
    for (int i = 0; i < gray_q.size(); i++) chk($sformatf("t1_gray%0d", i), gray_q[i], i + 1);

    // 2: missing pixel on the second slot of the first line
    mode = 1; src_n = 0; slot = 0; clr_stats();
    pulse_start();
    run_until_idle(100);
    chk("t2_pixels", gray_q.size(), VD * HD);
    chk("t2_vsync_len", vs_n, VTOT);
    if (gray_q.size() == VD * HD) begin
      chk("t2_gray_hole", gray_q[1], 0);
      chk("t2_gray_after", gray_q[2], 2);
      chk("t2_und_before", int'(und_q[0]), 0);
      chk("t2_und_set", int'(und_q[1]), 1);
      chk("t2_und_last", int'(und_q[11]), 1);
    end
    repeat (4) tick();
    chk("t2_und_sticky", int'(underrun), 1);

    // 3: continuous mode, three frames with random pixel gaps
    mode = 2; cont = 1'b1; clr_stats();
    pulse_start();
    chk("t3_und_cleared", int'(underrun), 0);
    n = 0;
    while (fd_q.size() < 3 && n < 200) begin tick(); n++; end
    chk("t3_fd_count", fd_q.size(), 3);
    cont = 1'b0;
    run_until_idle(100);
    chk("t3_frames", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      chk("t3_vs_period1", rise_q[1] - rise_q[0], PERIOD);
      chk("t3_vs_period2", rise_q[2] - rise_q[1], PERIOD);
    end
    if (fd_q.size() == 3) begin
      chk("t3_fd_period1", fd_q[1] - fd_q[0], PERIOD);
      chk("t3_fd_period2", fd_q[2] - fd_q[1], PERIOD);
    end
    chk("t3_idle_once", idle_n, 1);

    // 4: start during LINE and during GAP is ignored
    mode = 0; src_n = 0; clr_stats();
    pulse_start();
    n = 0;
    while (!pix_ready && n < 50) begin tick(); n++; end
    chk("t4_wait_line", int'(pix_ready), 1);
    pulse_start();
    n = 0;
    while (!frame_done && n < 50) begin tick(); n++; end
    chk("t4_wait_fd", int'(frame_done), 1);
    tick();
    pulse_start();
    run_until_idle(50);
    repeat (10) tick();
    chk("t4_idle_once", idle_n, 1);
    chk("t4_one_frame", rise_q.size(), 1);
    chk("t4_vsync_len", vs_n, VTOT);
    chk("t4_stays_idle", int'(busy), 0);

    // 5: reset in HBLK of the second line, then a clean frame
    mode = 0; src_n = 0; clr_stats();
    pulse_start();
    n = 0;
    while (!(m_act && m_off == VPR + LT + HD) && n < 60) begin tick(); n++; end
    chk("t5_wait_hblk", int'(img_href), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outputs", int'({img_vsync, img_href, img_gray, frame_done, busy, underrun, pix_ready}), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t5_no_fd", fd_n, 0);
    src_n = 0; clr_stats();
    pulse_start();
    run_until_idle(50);
    chk("t5_vsync_len", vs_n, VTOT);
    chk("t5_fd", fd_n, 1);
    chk("t5_pixels", gray_q.size(), VD * HD);
    for (int i = 0; i < gray_q.size(); i++) chk($sformatf("t5_gray%0d", i), gray_q[i], i + 1);

    // 6: constant image through a 5x5 Gaussian
    mode = 3; clr_stats();
    pulse_start();
    run_until_idle(50);
    chk("t6_pixels", gray_q.size(), VD * HD);
    chk("t6_lines", burst_n, VD);
    if (gray_q.size() == VD * HD) begin
      for (int y = 0; y < VD; y++)
        for (int x = 0; x < HD; x++) img[y][x] = int'(gray_q[y * HD + x]);
      for (int y = 0; y < VD; y++)
        for (int x = 0; x < HD; x++) chk($sformatf("t6_gauss_%0d_%0d", y, x), gauss(y, x), 128);
    end

    // 7: random starts, cont and pixel gaps against the model
    mode = 2;
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(7) == 0);
      cont  = ($urandom_range(1) == 1);
      tick();
    end
    start = 1'b0; cont = 1'b0;
    run_until_idle(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
